fifo_sync_param: RTL and testbench



---
 rtl/fifo_sync_param.sv | 139 +++++++++++++
 tb/tb_fifo_sync_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock parametrised FIFO with show-ahead read data.
// All DEPTH entries are usable; level counts stored words and drives every
// status flag, so no flag looks combinationally at wr or rd.
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags
// with a synchronous err_clr. Without the macro those ports and their logic
// are absent and everything else behaves the same.
module fifo_sync_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow,
`endif
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;

    logic wr_acc;
    logic rd_acc;

    // Accept decisions use only registered occupancy; flush overrides both.
    always_comb begin
        wr_acc = wr & ~full  & ~flush;
        rd_acc = rd & ~empty & ~flush;
    end

    // Next-state for pointers and level; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    // Show-ahead head word and occupancy-derived status.
    always_comb begin
        data_out     = mem_q[rd_ptr_q];
        level        = level_q;
        full         = (level_q == LVL_FULL);
        empty        = (level_q == '0);
        almost_full  = (level_q >= LVL_AF);
        almost_empty = (level_q <= LVL_AE);
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: a new violation wins over err_clr, flush clears.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr & full)   overflow_d  = 1'b1;
            else if (err_clr) overflow_d = 1'b0;
            if (rd & empty)   underflow_d = 1'b1;
            else if (err_clr) underflow_d = 1'b0;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Drive the error outputs from their registers.
    always_comb begin
        overflow  = overflow_q;
        underflow = underflow_q;
    end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param (default parameters): directed steps plus random
// traffic, checked against a queue-based reference model.
module tb_fifo_sync_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AFL    = DEPTH - 2;
    localparam int AEL    = 2;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              full, empty, almost_full, almost_empty;
    logic [LW-1:0]     level;
`ifdef FIFO_ERR_FLAGS_EN
    logic              err_clr = 1'b0;
    logic              overflow, underflow;
    bit                ov_m, uf_m;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] mq[$];

    fifo_sync_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .wr(wr),
        .data_in(data_in),
        .rd(rd),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr(err_clr),
        .overflow(overflow),
        .underflow(underflow),
`endif
        .data_out(data_out),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_outputs(input string ctx);
        int sz;
        sz = mq.size();
        chk({ctx, ".level"},        64'(level),        64'(sz));
        chk({ctx, ".empty"},        64'(empty),        64'(sz == 0));
        chk({ctx, ".full"},         64'(full),         64'(sz == DEPTH));
        chk({ctx, ".almost_full"},  64'(almost_full),  64'(sz >= AFL));
        chk({ctx, ".almost_empty"}, 64'(almost_empty), 64'(sz <= AEL));
        if (sz > 0) chk({ctx, ".data_out"}, 64'(data_out), 64'(mq[0]));
`ifdef FIFO_ERR_FLAGS_EN
        chk({ctx, ".overflow"},  64'(overflow),  64'(ov_m));
        chk({ctx, ".underflow"}, 64'(underflow), 64'(uf_m));
`endif
    endtask

    // One clock: drive at negedge, update model at posedge, check 1ns later.
    task automatic step(input string ctx, input bit w, input bit r, input bit f,
                        input logic [DATA_W-1:0] d, input bit clr);
        int sz;
        @(negedge clk);
        wr = w; rd = r; flush = f; data_in = d;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = clr;
`endif
        @(posedge clk);
        sz = mq.size();
`ifdef FIFO_ERR_FLAGS_EN
        if (f) begin
            ov_m = 1'b0; uf_m = 1'b0;
        end else begin
            if (w && sz == DEPTH) ov_m = 1'b1; else if (clr) ov_m = 1'b0;
            if (r && sz == 0)     uf_m = 1'b1; else if (clr) uf_m = 1'b0;
        end
`endif
        if (f) mq.delete();
        else begin
            if (r && sz > 0)     void'(mq.pop_front());
            if (w && sz < DEPTH) mq.push_back(d);
        end
        #1;
        check_outputs(ctx);
    endtask

    task automatic idle(input string ctx);
        step(ctx, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        bit w, r, f;

        // reset then idle
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("in_reset");
        @(negedge clk);
        reset = 1'b1;
        idle("post_reset");

        // fill 0x00..0x0F, then one ignored write into full
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 1'b0, DATA_W'(i), 1'b0);
        chk("full_after_16", 64'(full), 64'd1);
        step("wr_full", 1'b1, 1'b0, 1'b0, 8'hEE, 1'b0);

        // full with wr=rd: only the read happens, 0xAA dropped
        step("full_wr_rd", 1'b1, 1'b1, 1'b0, 8'hAA, 1'b0);
        chk("full_wr_rd_level", 64'(level), 64'(DEPTH - 1));

        // drain, then read from empty
        while (mq.size() > 0) step("drain", 1'b0, 1'b1, 1'b0, '0, 1'b0);
        step("rd_empty", 1'b0, 1'b1, 1'b0, '0, 1'b0);

        // empty with wr=rd: only the write happens
        step("empty_wr_rd", 1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
        chk("empty_wr_rd_data", 64'(data_out), 64'h55);
        step("pop55", 1'b0, 1'b1, 1'b0, '0, 1'b0);

        // wrap-around
        for (int i = 0; i < 10; i++) step("wrap_w", 1'b1, 1'b0, 1'b0, DATA_W'(8'h30 + i), 1'b0);
        for (int i = 0; i < 10; i++) step("wrap_r", 1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 12; i++) step("wrap_w2", 1'b1, 1'b0, 1'b0, DATA_W'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            chk("wrap_seq", 64'(data_out), 64'(8'hA0 + i));
            step("wrap_r2", 1'b0, 1'b1, 1'b0, '0, 1'b0);
        end

        // flush with concurrent write at level 7
        for (int i = 0; i < 7; i++) step("pre_flush", 1'b1, 1'b0, 1'b0, DATA_W'(i + 1), 1'b0);
        step("flush", 1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
        chk("flush_level", 64'(level), 64'd0);
        step("flush_rd", 1'b0, 1'b1, 1'b0, '0, 1'b0);

`ifdef FIFO_ERR_FLAGS_EN
        for (int i = 0; i < DEPTH + 1; i++) step("ovf_fill", 1'b1, 1'b0, 1'b0, DATA_W'(i), 1'b0);
        chk("overflow_set", 64'(overflow), 64'd1);
        idle("overflow_sticky");
        step("err_clr", 1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("overflow_clr", 64'(overflow), 64'd0);
        step("flush2", 1'b0, 1'b0, 1'b1, '0, 1'b0);
        step("udf", 1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("underflow_set", 64'(underflow), 64'd1);
`endif

        // random traffic: write-leaning, read-leaning, balanced phases
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 150; i++) begin
                w = ($urandom_range(99) < (ph == 0 ? 75 : (ph == 1 ? 25 : 50)));
                r = ($urandom_range(99) < (ph == 0 ? 25 : (ph == 1 ? 75 : 50)));
                f = ($urandom_range(59) == 0);
                d = DATA_W'($urandom);
                step("rand", w, r, f, d, ($urandom_range(9) == 0));
            end
        end

        // asynchronous reset between edges
        for (int i = 0; i < 5; i++) step("pre_arst", 1'b1, 1'b0, 1'b0, DATA_W'(8'hC0 + i), 1'b0);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; flush = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        #2;
        reset = 1'b0;
        mq.delete();
`ifdef FIFO_ERR_FLAGS_EN
        ov_m = 1'b0; uf_m = 1'b0;
`endif
        #1;
        check_outputs("async_reset");
        @(negedge clk);
        reset = 1'b1;
        idle("after_async_reset");
        step("after_arst_w", 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0);
        step("after_arst_r", 1'b0, 1'b1, 1'b0, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
